// File: rtl/oob_responder.sv
// Device-side SATA OOB responder: answers COMRESET with COMINIT,
// completes the COMWAKE exchange and locks on three consecutive ALIGNs.
module oob_responder #(
    parameter int unsigned INIT_CYCLES   = 162,
    parameter int unsigned WAKE_CYCLES   = 155,
    parameter int unsigned WAKE_TIMEOUT  = 132013,
    parameter int unsigned ALIGN_TIMEOUT = 132013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        platform_ready,
    input  logic        comm_reset_detect,
    input  logic        comm_wake_detect,
    input  logic        tx_oob_complete,
    input  logic [31:0] rx_din,
    input  logic [3:0]  rx_is_k,
    input  logic        phy_error,
    output logic        tx_comm_init,
    output logic        tx_comm_wake,
    output logic [31:0] tx_dout,
    output logic        tx_is_k,
    output logic        tx_set_elec_idle,
    output logic        linkup,
    output logic        platform_error,
    output logic [3:0]  lax_state
);

    localparam logic [31:0] ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC  = 32'hB5B5957C;

    typedef enum logic [3:0] {
        IDLE          = 4'd0,
        WAIT_NO_RESET = 4'd1,
        SEND_INIT     = 4'd2,
        WAIT_WAKE     = 4'd3,
        WAIT_NO_WAKE  = 4'd4,
        SEND_WAKE     = 4'd5,
        SEND_ALIGN    = 4'd6,
        READY         = 4'd7
    } state_t;

    state_t      state;
    state_t      nxt;
    logic [31:0] timer;
    logic [31:0] timer_dec;
    logic [1:0]  align_cnt;
    logic        timeout;
    logic        align_det;
    logic        reset_ovr;
    // Electrical idle must hold from power-up, before the first reset edge.
    logic        elec_idle = 1'b1;

    assign timeout   = (timer == 32'd0);
    assign timer_dec = timeout ? 32'd0 : timer - 32'd1;
    assign align_det = (rx_is_k != 4'd0) && (rx_din == ALIGN) && !phy_error;
    assign reset_ovr = comm_reset_detect
                     && (state >= SEND_INIT) && (state <= READY);

    assign lax_state        = state;
    assign tx_set_elec_idle = elec_idle;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:
                if (platform_ready && comm_reset_detect) nxt = WAIT_NO_RESET;
            WAIT_NO_RESET:
                if (!comm_reset_detect) nxt = SEND_INIT;
            SEND_INIT:
                if (timeout || tx_oob_complete) nxt = WAIT_WAKE;
            WAIT_WAKE:
                if (comm_wake_detect) nxt = WAIT_NO_WAKE;
                else if (timeout) nxt = IDLE;
            WAIT_NO_WAKE:
                if (!comm_wake_detect) nxt = SEND_WAKE;
            SEND_WAKE:
                if (timeout || tx_oob_complete) nxt = SEND_ALIGN;
            SEND_ALIGN:
                if (align_det && align_cnt == 2'd2) nxt = READY;
                else if (timeout) nxt = IDLE;
            READY:
                nxt = READY;
            default:
                nxt = IDLE;
        endcase
        if (reset_ovr) nxt = WAIT_NO_RESET;
    end

    // Outputs are decoded from the state being entered so they line up
    // with lax_state on the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            timer          <= 32'd0;
            align_cnt      <= 2'd0;
            tx_comm_init   <= 1'b0;
            tx_comm_wake   <= 1'b0;
            tx_dout        <= 32'd0;
            tx_is_k        <= 1'b0;
            elec_idle      <= 1'b1;
            linkup         <= 1'b0;
            platform_error <= 1'b0;
        end else begin
            state <= nxt;

            if (nxt != state) begin
                case (nxt)
                    SEND_INIT:  timer <= 32'(INIT_CYCLES);
                    WAIT_WAKE:  timer <= 32'(WAKE_TIMEOUT);
                    SEND_WAKE:  timer <= 32'(WAKE_CYCLES);
                    SEND_ALIGN: timer <= 32'(ALIGN_TIMEOUT);
                    default:    timer <= timer_dec;
                endcase
            end else begin
                timer <= timer_dec;
            end

            if (state == SEND_ALIGN && nxt == SEND_ALIGN && align_det)
                align_cnt <= align_cnt + 2'd1;
            else
                align_cnt <= 2'd0;

            tx_comm_init <= (nxt == SEND_INIT);
            tx_comm_wake <= (nxt == SEND_WAKE);
            tx_is_k      <= (nxt == SEND_ALIGN) || (nxt == READY);
            elec_idle    <= !((nxt == SEND_ALIGN) || (nxt == READY));
            linkup       <= (nxt == READY);

            case (nxt)
                SEND_ALIGN: tx_dout <= ALIGN;
                READY:      tx_dout <= SYNC;
                default:    tx_dout <= 32'd0;
            endcase

            if (nxt == IDLE)
                platform_error <= 1'b0;
            else if (state == READY && phy_error)
                platform_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_oob_responder.sv
// Directed bench for oob_responder with shortened timing parameters.
module tb_oob_responder;

    localparam int INIT_C  = 8;
    localparam int WAKE_C  = 6;
    localparam int WAKE_TO = 20;
    localparam int ALGN_TO = 30;

    localparam logic [31:0] ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC  = 32'hB5B5957C;
    localparam logic [31:0] D10_2 = 32'h4A4A4A4A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        platform_ready = 1'b0;
    logic        comm_reset_detect = 1'b0;
    logic        comm_wake_detect = 1'b0;
    logic        tx_oob_complete = 1'b0;
    logic [31:0] rx_din = 32'd0;
    logic [3:0]  rx_is_k = 4'd0;
    logic        phy_error = 1'b0;
    logic        tx_comm_init;
    logic        tx_comm_wake;
    logic [31:0] tx_dout;
    logic        tx_is_k;
    logic        tx_set_elec_idle;
    logic        linkup;
    logic        platform_error;
    logic [3:0]  lax_state;

    int errors = 0;
    int checks = 0;

    oob_responder #(
        .INIT_CYCLES  (INIT_C),
        .WAKE_CYCLES  (WAKE_C),
        .WAKE_TIMEOUT (WAKE_TO),
        .ALIGN_TIMEOUT(ALGN_TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .platform_ready   (platform_ready),
        .comm_reset_detect(comm_reset_detect),
        .comm_wake_detect (comm_wake_detect),
        .tx_oob_complete  (tx_oob_complete),
        .rx_din           (rx_din),
        .rx_is_k          (rx_is_k),
        .phy_error        (phy_error),
        .tx_comm_init     (tx_comm_init),
        .tx_comm_wake     (tx_comm_wake),
        .tx_dout          (tx_dout),
        .tx_is_k          (tx_is_k),
        .tx_set_elec_idle (tx_set_elec_idle),
        .linkup           (linkup),
        .platform_error   (platform_error),
        .lax_state        (lax_state)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rx(input logic [31:0] d, input logic [3:0] k,
                      input logic e);
        rx_din = d;
        rx_is_k = k;
        phy_error = e;
    endtask

    // Reset, then walk the handshake up to the first SEND_ALIGN cycle.
    task automatic to_align();
        rst = 1'b1;
        rx(32'd0, 4'd0, 1'b0);
        tick(1);
        rst = 1'b0;
        platform_ready = 1'b1;
        comm_reset_detect = 1'b1;
        tick(1);
        comm_reset_detect = 1'b0;
        tick(1);
        tx_oob_complete = 1'b1;
        tick(1);
        tx_oob_complete = 1'b0;
        comm_wake_detect = 1'b1;
        tick(1);
        comm_wake_detect = 1'b0;
        tick(1);
        tx_oob_complete = 1'b1;
        tick(1);
        tx_oob_complete = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (tx_set_elec_idle !== 1'b1) begin
            errors++;
            $display("FAIL powerup_idle got=%b want=1", tx_set_elec_idle);
        end
        tick(2);
        checks++;
        if ({lax_state, tx_comm_init, tx_comm_wake, tx_is_k,
             tx_set_elec_idle, linkup, platform_error} !== 10'b0000_000100) begin
            errors++;
            $display("FAIL reset_ctrl st=%0d ini=%b wk=%b k=%b ei=%b lu=%b pe=%b",
                     lax_state, tx_comm_init, tx_comm_wake, tx_is_k,
                     tx_set_elec_idle, linkup, platform_error);
        end
        checks++;
        if (tx_dout !== 32'd0) begin
            errors++;
            $display("FAIL reset_dout got=%h want=0", tx_dout);
        end
    endtask

    task automatic test_handshake();
        rst = 1'b0;
        platform_ready = 1'b1;
        comm_reset_detect = 1'b1;
        tick(1);
        checks++;
        if (lax_state !== 4'd1) begin
            errors++;
            $display("FAIL hs_wait_no_reset got=%0d want=1", lax_state);
        end
        comm_reset_detect = 1'b0;
        tick(1);
        checks++;
        if (lax_state !== 4'd2 || tx_comm_init !== 1'b1) begin
            errors++;
            $display("FAIL hs_send_init st=%0d init=%b want 2/1",
                     lax_state, tx_comm_init);
        end
        tx_oob_complete = 1'b1;
        tick(1);
        tx_oob_complete = 1'b0;
        checks++;
        if (lax_state !== 4'd3 || tx_comm_init !== 1'b0) begin
            errors++;
            $display("FAIL hs_wait_wake st=%0d init=%b want 3/0",
                     lax_state, tx_comm_init);
        end
        comm_wake_detect = 1'b1;
        tick(1);
        comm_wake_detect = 1'b0;
        tick(1);
        checks++;
        if (lax_state !== 4'd5 || tx_comm_wake !== 1'b1) begin
            errors++;
            $display("FAIL hs_send_wake st=%0d wake=%b want 5/1",
                     lax_state, tx_comm_wake);
        end
        tx_oob_complete = 1'b1;
        tick(1);
        tx_oob_complete = 1'b0;
        checks++;
        if (lax_state !== 4'd6 || tx_dout !== ALIGN || tx_is_k !== 1'b1
            || tx_set_elec_idle !== 1'b0 || tx_comm_wake !== 1'b0) begin
            errors++;
            $display("FAIL hs_align st=%0d dout=%h k=%b ei=%b want 6/%h/1/0",
                     lax_state, tx_dout, tx_is_k, tx_set_elec_idle, ALIGN);
        end
        rx(ALIGN, 4'b0001, 1'b0);
        tick(2);
        checks++;
        if (lax_state !== 4'd6 || linkup !== 1'b0) begin
            errors++;
            $display("FAIL hs_two_aligns st=%0d lu=%b want 6/0",
                     lax_state, linkup);
        end
        tick(1);
        checks++;
        if (lax_state !== 4'd7 || linkup !== 1'b1 || tx_dout !== SYNC
            || tx_is_k !== 1'b1) begin
            errors++;
            $display("FAIL hs_ready st=%0d lu=%b dout=%h k=%b want 7/1/%h/1",
                     lax_state, linkup, tx_dout, tx_is_k, SYNC);
        end
    endtask

    task automatic test_wake_timeout();
        rst = 1'b1;
        rx(32'd0, 4'd0, 1'b0);
        tick(1);
        rst = 1'b0;
        comm_reset_detect = 1'b1;
        tick(1);
        comm_reset_detect = 1'b0;
        tick(1);
        tick(INIT_C);
        checks++;
        if (lax_state !== 4'd2) begin
            errors++;
            $display("FAIL init_window_end got=%0d want=2", lax_state);
        end
        tick(1);
        checks++;
        if (lax_state !== 4'd3) begin
            errors++;
            $display("FAIL init_timeout got=%0d want=3", lax_state);
        end
        tick(WAKE_TO);
        checks++;
        if (lax_state !== 4'd3) begin
            errors++;
            $display("FAIL wake_window_end got=%0d want=3", lax_state);
        end
        tick(1);
        checks++;
        if (lax_state !== 4'd0 || linkup !== 1'b0) begin
            errors++;
            $display("FAIL wake_timeout st=%0d lu=%b want 0/0",
                     lax_state, linkup);
        end
    endtask

    task automatic test_align_break();
        logic [31:0] d [6];
        logic [3:0]  want [6];
        d = '{ALIGN, ALIGN, D10_2, ALIGN, ALIGN, ALIGN};
        want = '{4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd7};
        to_align();
        for (int i = 0; i < 6; i++) begin
            rx(d[i], (d[i] == ALIGN) ? 4'b0001 : 4'b0000, 1'b0);
            tick(1);
            checks++;
            if (lax_state !== want[i]) begin
                errors++;
                $display("FAIL align_break[%0d] got=%0d want=%0d",
                         i, lax_state, want[i]);
            end
        end
    endtask

    task automatic test_phy_error_align();
        logic        e [6];
        logic [3:0]  want [6];
        e = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        want = '{4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd7};
        to_align();
        for (int i = 0; i < 6; i++) begin
            rx(ALIGN, 4'b0001, e[i]);
            tick(1);
            checks++;
            if (lax_state !== want[i]) begin
                errors++;
                $display("FAIL align_phyerr[%0d] got=%0d want=%0d",
                         i, lax_state, want[i]);
            end
        end
        rx(32'd0, 4'd0, 1'b0);
    endtask

    task automatic test_platform_error();
        phy_error = 1'b1;
        tick(1);
        phy_error = 1'b0;
        checks++;
        if (platform_error !== 1'b1 || linkup !== 1'b1 || lax_state !== 4'd7) begin
            errors++;
            $display("FAIL perr_set pe=%b lu=%b st=%0d want 1/1/7",
                     platform_error, linkup, lax_state);
        end
        tick(3);
        checks++;
        if (platform_error !== 1'b1 || linkup !== 1'b1) begin
            errors++;
            $display("FAIL perr_sticky pe=%b lu=%b want 1/1",
                     platform_error, linkup);
        end
    endtask

    task automatic test_reset_in_ready();
        comm_reset_detect = 1'b1;
        tick(1);
        checks++;
        if (lax_state !== 4'd1 || linkup !== 1'b0 || tx_set_elec_idle !== 1'b1
            || tx_is_k !== 1'b0 || tx_dout !== 32'd0) begin
            errors++;
            $display("FAIL comreset_ready st=%0d lu=%b ei=%b k=%b dout=%h",
                     lax_state, linkup, tx_set_elec_idle, tx_is_k, tx_dout);
        end
        comm_reset_detect = 1'b0;
        tick(1);
        checks++;
        if (lax_state !== 4'd2 || tx_comm_init !== 1'b1) begin
            errors++;
            $display("FAIL comreset_reinit st=%0d init=%b want 2/1",
                     lax_state, tx_comm_init);
        end
    endtask

    task automatic test_align_timeout();
        to_align();
        tick(ALGN_TO);
        checks++;
        if (lax_state !== 4'd6) begin
            errors++;
            $display("FAIL align_window_end got=%0d want=6", lax_state);
        end
        tick(1);
        checks++;
        if (lax_state !== 4'd0 || tx_set_elec_idle !== 1'b1) begin
            errors++;
            $display("FAIL align_timeout st=%0d ei=%b want 0/1",
                     lax_state, tx_set_elec_idle);
        end
        to_align();
        tick(ALGN_TO - 2);
        rx(ALIGN, 4'b1000, 1'b0);
        tick(3);
        checks++;
        if (lax_state !== 4'd7) begin
            errors++;
            $display("FAIL align_vs_timeout got=%0d want=7", lax_state);
        end
        rx(32'd0, 4'd0, 1'b0);
    endtask

    task automatic test_rst_midway();
        to_align();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++;
        if (lax_state !== 4'd0 || tx_set_elec_idle !== 1'b1
            || tx_dout !== 32'd0 || tx_is_k !== 1'b0) begin
            errors++;
            $display("FAIL rst_midway st=%0d ei=%b dout=%h k=%b",
                     lax_state, tx_set_elec_idle, tx_dout, tx_is_k);
        end
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_platform_error();
        test_reset_in_ready();
        test_wake_timeout();
        test_align_break();
        test_phy_error_align();
        test_align_timeout();
        test_rst_midway();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
